// File: rtl/tt_um_spike_decoder.sv
// Spike decoder: turns a single-bit spike level into a windowed spike-rate
// count and the most recent inter-spike interval. Results are offered to an
// off-chip reader through a valid/ack handshake with sticky overrun.
module tt_um_spike_decoder #(
    parameter int WINDOW_LOG2 = 6
) (
    input  logic       clk,
    input  logic       rst_n,   // asynchronous, active-high despite the name
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = {WINDOW_LOG2{1'b1}};
    localparam logic [5:0]             ISI_MAX  = 6'd63;

    // Input field decode
    logic spike_in;
    logic ack_in;
    logic enable_in;

    assign spike_in  = ui_in[0];
    assign ack_in    = ui_in[1];
    assign enable_in = ui_in[2];

    // Inputs the block does not use, folded so they are visibly consumed
    logic unused_inputs;
    assign unused_inputs = ^{uio_in, ena, ui_in[7:3]};

    // State and datapath registers
    state_t                 state_q,      state_d;
    logic                   s1_q,         s2_q;
    logic [WINDOW_LOG2-1:0] win_cnt_q,    win_cnt_d;
    logic [7:0]             spike_cnt_q,  spike_cnt_d;
    logic [5:0]             isi_cnt_q,    isi_cnt_d;
    logic [7:0]             rate_q,       rate_d;
    logic [5:0]             isi_q,        isi_d;
    logic                   valid_q,      valid_d;
    logic                   overrun_q,    overrun_d;

    // Rising edge of the synchronised spike level
    logic spike_event;
    assign spike_event = s1_q & ~s2_q;

    // Saturating helpers for the two counters
    logic [8:0] spike_sum;
    logic [7:0] spike_sat;
    logic [5:0] isi_sat;
    logic       win_close;

    assign spike_sum = {1'b0, spike_cnt_q} + {8'd0, spike_event};
    assign spike_sat = spike_sum[8] ? 8'hFF : spike_sum[7:0];
    assign isi_sat   = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + 6'd1;
    assign win_close = (win_cnt_q == WIN_LAST);

    // Edge-detect pipeline runs regardless of FSM state
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= spike_in;
            s2_q <= s1_q;
        end
    end

    // Next-state logic: FSM, window/ISI counters and handshake
    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        spike_cnt_d = spike_cnt_q;
        isi_cnt_d   = isi_cnt_q;
        rate_d      = rate_q;
        isi_d       = isi_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;

        // Reader acknowledge works in every state; ignored when nothing is pending
        if (ack_in && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (!enable_in) begin
            // Dropping enable discards the partial window; results hold
            state_d     = ST_IDLE;
            win_cnt_d   = '0;
            spike_cnt_d = 8'd0;
            isi_cnt_d   = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Arming edge: counters are already zero, window starts here
                    state_d = ST_ARMED;
                end
                ST_ARMED, ST_RUN: begin
                    win_cnt_d = win_cnt_q + 1'b1;

                    if (win_close) begin
                        // Include this edge's event in the closing window
                        rate_d      = spike_sat;
                        spike_cnt_d = 8'd0;
                        valid_d     = 1'b1;
                        if (valid_q && !ack_in) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        spike_cnt_d = spike_sat;
                    end

                    if (spike_event) begin
                        isi_cnt_d = 6'd0;
                        if (state_q == ST_RUN) begin
                            // Two events N edges apart report N
                            isi_d = isi_sat;
                        end else begin
                            // First event only anchors the interval
                            state_d = ST_RUN;
                        end
                    end else begin
                        isi_cnt_d = isi_sat;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            win_cnt_q   <= '0;
            spike_cnt_q <= 8'd0;
            isi_cnt_q   <= 6'd0;
            rate_q      <= 8'd0;
            isi_q       <= 6'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            spike_cnt_q <= spike_cnt_d;
            isi_cnt_q   <= isi_cnt_d;
            rate_q      <= rate_d;
            isi_q       <= isi_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign uo_out  = rate_q;
    assign uio_out = {valid_q, overrun_q, isi_q};

    // Bidirectional pins are always driven as outputs
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_oe
            assign uio_oe[gi] = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_tt_um_spike_decoder.sv
// Directed bench for tt_um_spike_decoder (WINDOW_LOG2 = 6, 64-clock windows).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_tt_um_spike_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    int errors;
    int checks;

    // Optional periodic spike pattern: period per, high for hi clocks
    int per;
    int hi;
    int ph;

    tt_um_spike_decoder #(.WINDOW_LOG2(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (per > 0) begin
                ph = (ph + 1) % per;
                ui_in[0] = (ph < hi);
            end
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        per    = 0;
        hi     = 0;
        ph     = 0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        ena    = 1'b1;
        rst_n  = 1'b1;

        // Reset state
        step(3);
        check8("rst_uo", uo_out, 8'h00);
        check8("rst_uio", uio_out, 8'h00);
        check8("rst_oe", uio_oe, 8'hFF);
        rst_n = 1'b0;
        step(5);
        check8("idle_uo", uo_out, 8'h00);
        check8("idle_uio", uio_out, 8'h00);

        // Held level: one event per rising edge, ISI untouched by first event
        ui_in = 8'h05;
        step(64);
        check8("held_preclose", uio_out, 8'h00);
        step(1);
        check8("held_rate", uo_out, 8'h01);
        check8("held_uio", uio_out, 8'h80);
        ui_in[1] = 1'b1;
        step(1);
        check8("held_ack", uio_out, 8'h00);
        ui_in = 8'h00;
        step(2);
        check8("idle_hold_uo", uo_out, 8'h01);

        // Periodic spikes, period 4
        ui_in = 8'h05;
        per = 4; hi = 2; ph = 0;
        step(64);
        check8("per_preclose", uio_out, 8'h04);
        step(1);
        check8("per_rate1", uo_out, 8'd16);
        check8("per_uio1", uio_out, 8'h84);
        ui_in[1] = 1'b1;
        step(1);
        check8("per_ack1", uio_out, 8'h04);
        ui_in[1] = 1'b0;
        step(63);
        check8("per_rate2", uo_out, 8'd16);
        check8("per_uio2", uio_out, 8'h84);

        // Overrun: second close without ack
        step(64);
        check8("ovr_uio", uio_out, 8'hC4);
        check8("ovr_rate", uo_out, 8'd16);
        ui_in[1] = 1'b1;
        step(1);
        check8("ovr_ack", uio_out, 8'h04);
        ui_in[1] = 1'b0;
        step(63);
        check8("per_uio4", uio_out, 8'h84);
        // ack on the exact close edge while valid is still set
        step(63);
        ui_in[1] = 1'b1;
        step(1);
        check8("close_ack", uio_out, 8'h84);
        step(1);
        check8("close_ack2", uio_out, 8'h04);
        ui_in[1] = 1'b0;

        // Enable drop at clock 30 of the window
        per = 0;
        ui_in[0] = 1'b0;
        step(29);
        ui_in[2] = 1'b0;
        step(6);
        check8("drop_uo", uo_out, 8'd16);
        check8("drop_uio", uio_out, 8'h04);

        // Re-enable: first event keeps ISI, second sets it to 10
        ui_in[2] = 1'b1;
        step(1);
        ui_in[0] = 1'b1;
        step(1);
        ui_in[0] = 1'b0;
        step(1);
        check8("reen_first", uio_out, 8'h04);
        step(8);
        ui_in[0] = 1'b1;
        step(1);
        ui_in[0] = 1'b0;
        step(1);
        check8("reen_isi", uio_out, 8'h0A);
        step(51);
        check8("reen_pre_uo", uo_out, 8'd16);
        check8("reen_pre_uio", uio_out, 8'h0A);
        step(1);
        check8("reen_rate", uo_out, 8'd2);
        check8("reen_uio", uio_out, 8'h8A);
        ui_in[1] = 1'b1;
        step(1);
        ui_in[1] = 1'b0;

        // ISI saturation with spike period 100
        per = 100; hi = 1; ph = 80;
        ui_in[0] = 1'b0;
        step(63);
        check8("sat_rate1", uo_out, 8'd1);
        check8("sat_uio1", uio_out, 8'hBF);
        ui_in[1] = 1'b1;
        step(1);
        ui_in[1] = 1'b0;
        check8("sat_ack", uio_out, 8'h3F);
        step(63);
        check8("sat_rate2", uo_out, 8'd1);
        check8("sat_uio2", uio_out, 8'hBF);
        ui_in[1] = 1'b1;
        step(1);
        ui_in[1] = 1'b0;
        step(63);
        check8("sat_rate3", uo_out, 8'd0);
        check8("sat_uio3", uio_out, 8'hBF);

        // Asynchronous reset mid-operation with the spike still toggling
        #2;
        rst_n = 1'b1;
        #1;
        check8("arst_uo", uo_out, 8'h00);
        check8("arst_uio", uio_out, 8'h00);
        step(3);
        rst_n = 1'b0;
        ui_in[2:1] = 2'b00;
        step(8);
        check8("post_uo", uo_out, 8'h00);
        check8("post_uio", uio_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
